// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine host driver and the engine wrapper:
// controller states, default bus width and the default wait bound.
package gcd_pkg;

    localparam int GCD_WIDTH      = 16;
    localparam int GCD_MAX_CYCLES = 70000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4,
        CLEAR  = 3'd5
    } gcd_state_e;

    // Counter width able to hold every value from 0 up to max_cycles without wrapping.
    function automatic int gcd_ctr_width(input int max_cycles);
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/gcd_req_driver_if.sv
// Request/response channel plus engine operand bus between the GCD driver (master)
// and its environment: host client and engine (slave).
interface gcd_req_driver_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_gcd;
    logic             rsp_err;

    logic [WIDTH-1:0] eng_data;
    logic             eng_start;
    logic             eng_clr;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;

    modport master (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        input  eng_done,
        input  eng_result,
        output req_ready,
        output rsp_valid,
        output rsp_gcd,
        output rsp_err,
        output eng_data,
        output eng_start,
        output eng_clr
    );

    modport slave (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        output eng_done,
        output eng_result,
        input  req_ready,
        input  rsp_valid,
        input  rsp_gcd,
        input  rsp_err,
        input  eng_data,
        input  eng_start,
        input  eng_clr
    );

endinterface

// File: rtl/gcd_timeout_ctr.sv
// Wait-cycle counter for the GCD driver; expired is registered and is high while
// the count equals MAX_CYCLES-1, i.e. during the MAX_CYCLES-th enabled cycle.
module gcd_timeout_ctr
    import gcd_pkg::*;
#(
    parameter int MAX_CYCLES = GCD_MAX_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW    = gcd_ctr_width(MAX_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(MAX_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Next count: clear wins, otherwise count enabled cycles and hold at LIMIT.
    always_comb begin
        if (clr) begin
            cnt_next = '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt_next = cnt + ONE;
        end else begin
            cnt_next = cnt;
        end
    end

    // Count register; expired tracks the new count so it lines up with cnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            expired <= (LAST == '0);
        end else begin
            cnt     <= cnt_next;
            expired <= (cnt_next == LAST);
        end
    end

endmodule

// File: rtl/gcd_req_driver.sv
// Host-side initiator for the subtractive GCD engine: accepts an operand pair, drives
// A then B onto the engine bus, bounds the wait, and returns the result or an error.
module gcd_req_driver
    import gcd_pkg::*;
#(
    parameter int WIDTH      = GCD_WIDTH,
    parameter int MAX_CYCLES = GCD_MAX_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    gcd_req_driver_if.master bus
);

    gcd_state_e       state;
    logic [WIDTH-1:0] op_b;
    logic             tmo_clr;
    logic             tmo_en;
    logic             tmo_expired;
    logic             a_zero;
    logic             b_zero;

    // Counter control and operand zero detection.
    always_comb begin
        tmo_clr = (state == CLEAR);
        tmo_en  = (state == WAIT);
        a_zero  = (bus.req_a == '0);
        b_zero  = (bus.req_b == '0);
    end

    gcd_timeout_ctr #(
        .MAX_CYCLES(MAX_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    // Controller: state and every output register are updated together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= CLEAR;
            op_b          <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_gcd   <= '0;
            bus.rsp_err   <= 1'b0;
            bus.eng_data  <= '0;
            bus.eng_start <= 1'b0;
            bus.eng_clr   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        op_b          <= bus.req_b;
                        // Zero operands never reach the engine: gcd(x,0)=x, gcd(0,0) is an error.
                        if (a_zero && b_zero) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_gcd   <= '0;
                            bus.rsp_err   <= 1'b1;
                        end else if (a_zero) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_gcd   <= bus.req_b;
                            bus.rsp_err   <= 1'b0;
                        end else if (b_zero) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_gcd   <= bus.req_a;
                            bus.rsp_err   <= 1'b0;
                        end else begin
                            state         <= LOAD_A;
                            bus.eng_data  <= bus.req_a;
                            bus.eng_start <= 1'b1;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                LOAD_A: begin
                    state         <= LOAD_B;
                    bus.eng_data  <= op_b;
                    bus.eng_start <= 1'b0;
                end
                LOAD_B: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.eng_done) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_gcd   <= bus.eng_result;
                        bus.rsp_err   <= 1'b0;
                    end else if (tmo_expired) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_gcd   <= '0;
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= CLEAR;
                        bus.rsp_valid <= 1'b0;
                        bus.eng_clr   <= 1'b1;
                    end else begin
                        state <= RESP;
                    end
                end
                CLEAR: begin
                    state         <= IDLE;
                    bus.eng_clr   <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= CLEAR;
                    bus.req_ready <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    bus.eng_start <= 1'b0;
                    bus.eng_clr   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_req_driver.sv
// Bench for gcd_req_driver: directed table, timeout/reset sequences and random jobs
// against a behavioural subtractive engine and a Euclid reference model.
module tb_gcd_req_driver;
    import gcd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_req_driver_if #(.WIDTH(16)) bus ();
    gcd_req_driver_if #(.WIDTH(16)) bus8 ();

    gcd_req_driver #(.WIDTH(16), .MAX_CYCLES(GCD_MAX_CYCLES)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    gcd_req_driver #(.WIDTH(16), .MAX_CYCLES(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus8.master)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural engine: A on start, B next cycle, then repeated subtraction; done sticky.
    int          eph    = 0;
    logic [15:0] ea     = 16'd0;
    logic [15:0] eb     = 16'd0;
    logic        e_done = 1'b0;
    assign bus.eng_done   = e_done;
    assign bus.eng_result = ea;

    always @(posedge clk) begin
        if (bus.eng_clr === 1'b1) begin
            eph    <= 0;
            e_done <= 1'b0;
        end else begin
            case (eph)
                0: if (bus.eng_start === 1'b1) begin ea <= bus.eng_data; eph <= 1; end
                1: begin eb <= bus.eng_data; eph <= 2; end
                default: begin
                    if (eb == 16'd0) e_done <= 1'b1;
                    else if (ea < eb) begin ea <= eb; eb <= ea; end
                    else ea <= ea - eb;
                end
            endcase
        end
    end

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x = a;
        logic [15:0] y = b;
        logic [15:0] t;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_gcd"},   bus.rsp_gcd,   0);
        chk({tag, "_rsp_err"},   bus.rsp_err,   0);
        chk({tag, "_eng_start"}, bus.eng_start, 0);
        chk({tag, "_eng_data"},  bus.eng_data,  0);
        chk({tag, "_eng_clr"},   bus.eng_clr,   1);
    endtask

    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eg,
                           input logic ee, input int hold);
        bit ok     = 1'b0;
        bit nz     = (a != 16'd0) && (b != 16'd0);
        int rsp_c  = -1;
        int done_c = -1;
        int starts = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.req_ready === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        chk("req_ready_before_job", 32'(ok), 1);
        if (!ok) return;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        tick();
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            if (bus.eng_start === 1'b1) starts++;
            if (nz && c == 1) begin
                chk("load_a_start", bus.eng_start, 1);
                chk("load_a_data", bus.eng_data, a);
            end
            if (nz && c == 2) begin
                chk("load_b_start", bus.eng_start, 0);
                chk("load_b_data", bus.eng_data, b);
            end
            if (bus.rsp_valid === 1'b1) begin rsp_c = c; break; end
            if (bus.eng_done === 1'b1 && done_c < 0) done_c = c;
            tick();
        end
        if (rsp_c < 0) begin
            chk("rsp_wait_expired", 0, 1);
            return;
        end
        chk("rsp_latency", rsp_c, nz ? done_c + 1 : 1);
        chk("start_pulses", starts, nz ? 1 : 0);
        chk("rsp_gcd", bus.rsp_gcd, eg);
        chk("rsp_err", bus.rsp_err, ee);
        chk("req_ready_in_resp", bus.req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            tick();
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_gcd", bus.rsp_gcd, eg);
            chk("hold_err", bus.rsp_err, ee);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("clear_rsp_valid", bus.rsp_valid, 0);
        chk("clear_eng_clr", bus.eng_clr, 1);
        chk("clear_req_ready", bus.req_ready, 0);
        tick();
        chk("idle_eng_clr", bus.eng_clr, 0);
        chk("idle_req_ready", bus.req_ready, 1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] gcd;
        logic        err;
        int          hold;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;

        vt[0] = '{16'd48, 16'd18, 16'd6, 1'b0, 0};
        vt[1] = '{16'd0,  16'd7,  16'd7, 1'b0, 0};
        vt[2] = '{16'd9,  16'd0,  16'd9, 1'b0, 0};
        vt[3] = '{16'd0,  16'd0,  16'd0, 1'b1, 0};
        vt[4] = '{16'd35, 16'd21, 16'd7, 1'b0, 5};
        vt[5] = '{16'd12, 16'd8,  16'd4, 1'b0, 0};

        bus.req_valid   = 1'b0;
        bus.req_a       = 16'd0;
        bus.req_b       = 16'd0;
        bus.rsp_ready   = 1'b0;
        bus8.req_valid  = 1'b0;
        bus8.req_a      = 16'd0;
        bus8.req_b      = 16'd0;
        bus8.rsp_ready  = 1'b0;
        bus8.eng_done   = 1'b0;
        bus8.eng_result = 16'd0;

        rst_n = 1'b0;
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk("post_reset_req_ready", bus.req_ready, 1);
        chk("post_reset_eng_clr", bus.eng_clr, 0);

        for (int i = 0; i < 6; i++) begin
            run_job(vt[i].a, vt[i].b, vt[i].gcd, vt[i].err, vt[i].hold);
        end

        // Timeout: engine never finishes, error must appear 8 cycles after entering WAIT.
        chk("t8_ready", bus8.req_ready, 1);
        bus8.req_valid = 1'b1;
        bus8.req_a     = 16'd5;
        bus8.req_b     = 16'd3;
        tick();
        bus8.req_valid = 1'b0;
        repeat (9) tick();
        chk("t8_no_early_rsp", bus8.rsp_valid, 0);
        tick();
        chk("t8_tmo_valid", bus8.rsp_valid, 1);
        chk("t8_tmo_err", bus8.rsp_err, 1);
        chk("t8_tmo_gcd", bus8.rsp_gcd, 0);
        bus8.rsp_ready = 1'b1;
        tick();
        bus8.rsp_ready = 1'b0;
        tick();
        chk("t8_ready_again", bus8.req_ready, 1);

        // Done arriving on the final WAIT cycle beats the timeout.
        bus8.req_valid = 1'b1;
        tick();
        bus8.req_valid = 1'b0;
        repeat (9) tick();
        bus8.eng_done   = 1'b1;
        bus8.eng_result = 16'd42;
        tick();
        chk("t8_done_valid", bus8.rsp_valid, 1);
        chk("t8_done_err", bus8.rsp_err, 0);
        chk("t8_done_gcd", bus8.rsp_gcd, 42);
        bus8.rsp_ready = 1'b1;
        tick();
        bus8.rsp_ready = 1'b0;
        bus8.eng_done  = 1'b0;
        tick();

        // Reset in the middle of a long WAIT abandons the job silently.
        chk("mid_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_a     = 16'd1000;
        bus.req_b     = 16'd3;
        tick();
        bus.req_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_outputs("mid_reset");
        tick();
        chk("mid_idle_ready", bus.req_ready, 1);
        chk("mid_idle_no_rsp", bus.rsp_valid, 0);
        chk("mid_idle_eng_clr", bus.eng_clr, 0);
        run_job(16'd10, 16'd4, 16'd2, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
            run_job(ra, rb, ref_gcd(ra, rb), (ra == 16'd0) && (rb == 16'd0),
                    int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_req_driver.md
Name: gcd_req_driver

Overview:
Host-side initiator for the subtractive GCD engine (datapath plus controller). It accepts an operand pair over a valid/ready request channel and sequences the engine's shared operand bus: A on the start cycle, then B. It waits for done, captures the result and returns it over a valid/ready response channel. It also handles zero operands locally, bounds the wait with a timeout, and clears the engine between jobs.

Parameters:
WIDTH, 16, operand/result width; matches engine bus width
MAX_CYCLES, 70000, max WAIT cycles before timeout; must cover worst case gcd(2^WIDTH-1,1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset; one clock, synchronous, active-low
req_valid  in  1  operand pair valid
req_ready  out  1  driver can accept a pair
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_gcd  out  WIDTH  GCD result (0 when rsp_err)
rsp_err  out  1  both operands zero, or timeout
eng_data  out  WIDTH  engine data_in bus
eng_start  out  1  engine start
eng_clr  out  1  engine clear; returns engine controller to load-A state
eng_done  in  1  engine done; sticky until cleared
eng_result  in  WIDTH  engine A-register value, valid while eng_done=1

Behaviour:
- All outputs registered.
- Reset (rst_n=0 at a clk edge): state=CLEAR, req_ready=0, rsp_valid=0, rsp_gcd=0, rsp_err=0, eng_start=0, eng_data=0, eng_clr=1, timeout counter=0.
- Reset mid-operation abandons the job with no response. The engine is cleared by the CLEAR pass that follows.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch A and B.
    - If A=0 and B=0: go to RESP, err=1, gcd=0.
    - Else if A=0: go to RESP, gcd=B.
    - Else if B=0: go to RESP, gcd=A.
    - Else: go to LOAD_A.
  - LOAD_A (1 cycle): eng_data=A, eng_start=1.
  - LOAD_B (1 cycle): eng_data=B, eng_start=0.
  - WAIT: eng_data holds B; counter increments each cycle.
    - If eng_done=1: capture eng_result into rsp_gcd, err=0, go to RESP.
    - Else if counter==MAX_CYCLES-1: rsp_gcd=0, err=1, go to RESP.
    - If done and timeout occur in the same cycle, done wins.
  - RESP: rsp_valid=1; rsp_gcd and rsp_err stay stable until rsp_valid&&rsp_ready, then go to CLEAR.
  - CLEAR (1 cycle): eng_clr=1, counter=0, go to IDLE.
- req_ready=0 in every state except IDLE.
- eng_done is ignored outside WAIT.
- eng_start is high only in LOAD_A.
- Latency, non-zero operands: handshake at cycle 0, LOAD_A at 1, LOAD_B at 2, WAIT from 3. With done seen at cycle k, rsp_valid is high at k+1.
- Latency, zero operand: rsp_valid at cycle 1.
- Throughput: one job in flight. Next req_ready comes 2 cycles after the response handshake (CLEAR, then IDLE).
- Widths: counter is $clog2(MAX_CYCLES+1) bits and does not wrap; the timeout terminates it. Results pass through unmodified, with no arithmetic.

Decomposition:
- gcd_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, WAIT, RESP, CLEAR)
  - GCD_WIDTH default 16
  - GCD_MAX_CYCLES default
- These are shared with the engine wrapper.
- One sub-module, gcd_timeout_ctr: clear, enable and expired signals, parameterised by MAX_CYCLES.

Test Plan:
- (48,18) with behavioural engine model -> eng_start high exactly 1 cycle with eng_data=48, next cycle eng_data=18; rsp_valid with rsp_gcd=6, rsp_err=0; eng_clr pulses once after the handshake.
- (0,7), then (9,0) -> rsp_valid one cycle after each handshake with rsp_gcd=7 and 9; eng_start never asserted.
- (0,0) -> rsp_err=1, rsp_gcd=0 one cycle after handshake.
- MAX_CYCLES=8, engine model never asserts done -> rsp_err=1, rsp_gcd=0 exactly 8 cycles after entering WAIT; eng_done raised on the 8th WAIT cycle instead -> rsp_err=0, result captured.
- (35,21) -> rsp_gcd=7 with rsp_ready held low 5 cycles; rsp_valid, rsp_gcd and rsp_err stable; req_ready=0 throughout; back-to-back (12,8) afterwards -> 4.
- rst_n low for one cycle during WAIT of (1000,3) -> next cycle all outputs at reset values with eng_clr=1, no response; then IDLE; new job (10,4) -> 2.
